lsu_ctrl: RTL and testbench

- Load/store unit controller for the RISC-V core.
- Takes one load or store per instruction and drives a request/grant/response data-memory bus.
- Generates byte enables and write-data lane replication, and aligns and sign- or zero-extends load data.
- Stalls the core until the access completes, and flags misaligned, illegal, bus-error and grant-timeout accesses.

---
 rtl/risc_pkg.sv | 51 +++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared core definitions: load/store encodings, LSU state, access-size decode.
// Imported by the LSU controller and its alignment helper.
package risc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Low two funct3 bits give the size; bit 2 marks unsigned loads.
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        DMEM_B = 2'd0,
        DMEM_H = 2'd1,
        DMEM_W = 2'd2,
        DMEM_X = 2'd3
    } op_dmem_size;

    function automatic op_dmem_size dmem_size(input logic [2:0] f3);
        return op_dmem_size'(f3[1:0]);
    endfunction

    function automatic logic access_illegal(input logic we,
                                            input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 > F3_SW);
        end else begin
            bad = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                    f3 == F3_LBU || f3 == F3_LHU);
        end
        return bad;
    endfunction

    function automatic logic access_misaligned(input op_dmem_size sz,
                                               input logic [1:0] off);
        return (sz == DMEM_H && off[0]) ||
               (sz == DMEM_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: store byte enables and lane replication, load
// extraction with sign/zero extension. Purely combinational.
module lsu_align
    import risc_pkg::*;
(
    input  op_dmem_size st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_uns;

    always_comb begin
        be    = 4'b0000;
        wlane = st_data;
        case (st_size)
            DMEM_B: begin
                be    = 4'b0001 << st_off;
                wlane = {4{st_data[7:0]}};
            end
            DMEM_H: begin
                be    = 4'b0011 << st_off;
                wlane = {2{st_data[15:0]}};
            end
            DMEM_W: begin
                be    = 4'b1111;
            end
            default: begin
                be    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_off)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
    end

    assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    assign ld_uns  = ld_funct3[2];

    always_comb begin
        ld_data = ld_word;
        case (dmem_size(ld_funct3))
            DMEM_B: ld_data = {{24{!ld_uns && ld_byte[7]}}, ld_byte};
            DMEM_H: ld_data = {{16{!ld_uns && ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access per instruction over a req/gnt/rvalid
// bus, stalling the core until done_o; flags misaligned/illegal/bus/timeout.
// Ports: core side req_i/we_i/funct3_i/addr_i/wdata_i -> stall_o/done_o/
// err_o/rdata_o; bus side mem_req_o/we/addr/be/wdata, mem_gnt_i/rvalid/rdata/err.
module lsu_ctrl
    import risc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            err_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    lsu_state_t      state;
    lsu_state_t      state_nx;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [3:0]      be_q;
    logic            err_q;

    op_dmem_size     size_in;
    logic            bad_in;
    logic            timeout;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wlane_in;
    logic [XLEN-1:0] ld_data;

    assign size_in = dmem_size(funct3_i);
    assign bad_in  = access_illegal(we_i, funct3_i) ||
                     access_misaligned(size_in, addr_i[1:0]);
    // Last grant-less REQ cycle: after this the access is abandoned.
    assign timeout = (cnt == CW'(GNT_TIMEOUT - 1));

    lsu_align u_align (
        .st_size   (size_in),
        .st_off    (addr_i[1:0]),
        .st_data   (wdata_i),
        .be        (be_in),
        .wlane     (wlane_in),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (mem_rdata_i),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    state_nx = bad_in ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_nx = WAIT;
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        err_q <= bad_in;
                        cnt   <= '0;
                        if (!bad_in) begin
                            we_q    <= we_i;
                            f3_q    <= funct3_i;
                            off_q   <= addr_i[1:0];
                            addr_q  <= {addr_i[XLEN-1:2], 2'b00};
                            be_q    <= be_in;
                            wdata_q <= wlane_in;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        err_q <= mem_err_i;
                        // Failed loads keep the previous result visible.
                        if (!we_q && !mem_err_i) begin
                            rdata_q <= ld_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_o     = req_i && (state != DONE);
    assign done_o      = (state == DONE);
    assign err_o       = (state == DONE) && err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// accesses checked against a byte-lane reference model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .GNT_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        if (f3[1:0] == 2'd2) return 4;
        return 0;
    endfunction

    function automatic bit pre_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
        bit ill;
        int n;
        if (we) ill = (f3 > 3'd2);
        else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (ill) return 1'b1;
        n = nbytes(f3);
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3,
                                            input logic [31:0] a);
        logic [3:0] be;
        int off;
        int n;
        off = int'(a % 4);
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3,
                                                input logic [31:0] wd);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * (a % 4));
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic access(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gdly,
                          input int rdly, input logic [31:0] rd,
                          input logic merr);
        bit perr;
        bit got;
        bit exp_err;
        int cyc;
        int reqs;
        int stalls;
        int gnt_cyc;
        int done_cyc;
        int exp_done;
        int exp_reqs;
        perr = pre_err(we, f3, a);
        if (perr) begin
            exp_done = 1;
            exp_reqs = 0;
            exp_err  = 1'b1;
        end else if (gdly >= TO) begin
            exp_done = 1 + TO;
            exp_reqs = TO;
            exp_err  = 1'b1;
        end else begin
            exp_done = 3 + gdly + rdly;
            exp_reqs = gdly + 1;
            exp_err  = merr;
            if (!we && !merr) exp_rdata = model_load(f3, a, rd);
        end
        @(negedge clk);
        req_i = 1'b1;
        we_i = we;
        funct3_i = f3;
        addr_i = a;
        wdata_i = wd;
        cyc = 0;
        reqs = 0;
        stalls = 0;
        got = 1'b0;
        gnt_cyc = -1;
        done_cyc = -1;
        while (!got && cyc < 100) begin
            #1;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_err_i = 1'b0;
            mem_rdata_i = $urandom;
            if (stall_o) stalls++;
            if (mem_req_o) begin
                reqs++;
                chk({tag, "_addr"}, mem_addr_o, a & 32'hFFFF_FFFC);
                chk({tag, "_be"}, 32'(mem_be_o), 32'(model_be(f3, a)));
                chk({tag, "_we"}, 32'(mem_we_o), 32'(we));
                if (we) chk({tag, "_wdata"}, mem_wdata_o, model_wdata(f3, wd));
                if (reqs > gdly && gnt_cyc < 0) begin
                    mem_gnt_i = 1'b1;
                    gnt_cyc = cyc;
                end
            end
            if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 + rdly) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = rd;
                mem_err_i = merr;
            end
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
                chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
                chk({tag, "_rdata"}, rdata_o, exp_rdata);
                req_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i = 1'b0;
        chk({tag, "_got_done"}, 32'(got), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_done));
    endtask

    initial begin
        int gsel;
        logic [2:0] f3r;
        logic [31:0] ar;
        bit wer;

        // reset state
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_mreq", 32'(mem_req_o), 32'd0);
        chk("rst_mwe", 32'(mem_we_o), 32'd0);
        chk("rst_maddr", mem_addr_o, 32'd0);
        chk("rst_mbe", 32'(mem_be_o), 32'd0);
        chk("rst_mwdata", mem_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed
        access("lw_min", 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        access("lb", 1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF1234, 1'b0);
        chk("lb_val", rdata_o, 32'hFFFF_FF80);
        access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 1, 1, 32'h80FF1234, 1'b0);
        chk("lbu_val", rdata_o, 32'h0000_0080);
        access("sh", 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 0, 0, 32'h0, 1'b0);
        chk("sh_be", 32'(mem_be_o), 32'h0000_000C);
        chk("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        access("lh", 1'b0, 3'd1, 32'h306, 32'h0, 2, 0, 32'h9234_5678, 1'b0);
        chk("lh_val", rdata_o, 32'hFFFF_9234);
        access("lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        access("sh_mis", 1'b1, 3'd1, 32'h3, 32'h0, 0, 0, 32'h0, 1'b0);
        access("ld_f3_3", 1'b0, 3'd3, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0);
        access("st_f3_4", 1'b1, 3'd4, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0);
        access("gnt_to", 1'b0, 3'd2, 32'h500, 32'h0, 10, 0, 32'h0, 1'b0);
        access("bus_err", 1'b0, 3'd2, 32'h600, 32'h0, 0, 1, 32'h12345678,
               1'b1);
        chk("bus_err_keep", rdata_o, 32'h9234_5678 >> 16 | 32'hFFFF_0000);

        // reset while waiting for the response
        @(negedge clk);
        req_i = 1'b1;
        we_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'h40;
        @(negedge clk);
        #1;
        chk("rw_req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        #1;
        mem_gnt_i = 1'b0;
        req_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_mreq", 32'(mem_req_o), 32'd0);
        chk("rw_done", 32'(done_o), 32'd0);
        chk("rw_rdata", rdata_o, 32'd0);
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            #1;
            chk("rw_late_done", 32'(done_o), 32'd0);
        end
        chk("rw_late_rdata", rdata_o, 32'd0);
        access("b2b_lw", 1'b0, 3'd2, 32'h80, 32'h0, 0, 0, 32'h13572468, 1'b0);
        access("b2b_sw", 1'b1, 3'd2, 32'h84, 32'h11223344, 0, 0, 32'h0, 1'b0);
        chk("b2b_rdata", rdata_o, 32'h13572468);

        // randomized
        for (int k = 0; k < 80; k++) begin
            wer = 1'($urandom);
            if ($urandom_range(0, 9) == 0) f3r = 3'($urandom);
            else if (wer) f3r = 3'($urandom_range(0, 2));
            else begin
                f3r = 3'($urandom_range(0, 4));
                if (f3r == 3'd3) f3r = 3'd5;
            end
            ar = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (nbytes(f3r) == 2) ar[0] = 1'b0;
                if (nbytes(f3r) == 4) ar[1:0] = 2'b00;
            end
            gsel = $urandom_range(0, 9);
            access("rnd", wer, f3r, ar, $urandom,
                   (gsel >= 8) ? TO + 1 : gsel % 4, $urandom_range(0, 2),
                   $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
